coeff_update_sequencer: RTL and testbench
=========================================

Name: coeff_update_sequencer

Overview:
- Sits between the Nios II PIO exports and the 32-tap signal path.
- Turns level-style CPU PIO writes (update_control/update_value) into single-cycle, FIFO-buffered coefficient write pulses, issued only when the FIR is idle.
- Owns the per-axis active-bank selects; a requested bank swap commits only at a sample boundary, and only once no writes to that bank remain pending.

Parameters:
- FIFO_DEPTH, 8, pending-write FIFO entries; power of 2, minimum 2.
- COEFF_W, 16, coefficient width.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_update_ctrl  in  10  [9]commit, [8:7]axis, [6:5]bank, [4:0]index.
- cpu_update_value  in  COEFF_W  coefficient value from CPU.
- x_bank_req / y_bank_req / z_bank_req  in  2 each  requested active bank per axis.
- err_clear  in  1  one-cycle pulse; clears sticky errors.
- sample_strobe  in  1  one-cycle pulse at each sample boundary.
- fir_busy  in  1  FIR MAC in progress; no coefficient writes allowed.
- update_en  out  1  one-cycle write pulse to the signal path.
- update_axis  out  2  axis of the write (0=x, 1=y, 2=z).
- update_bank  out  2  bank of the write.
- update_index  out  5  tap index of the write.
- update_value  out  COEFF_W  coefficient of the write.
- x_bank / y_bank / z_bank  out  2 each  committed active banks.
- fifo_level  out  LVL_W  pending write count.
- swap_pending  out  3  {z,y,x} swap requested but not yet committed.
- overflow_err  out  1  sticky: write dropped because FIFO full.
- conflict_err  out  1  sticky: write to active bank or to axis 3 rejected.
- issued_count  out  16  see Optional Feature.

Behaviour:
- Reset (synchronous) forces:
  - update_en=0, all update_* buses=0.
  - x/y/z_bank=0, swap_pending=0, fifo_level=0, both error flags=0, issued_count=0.
  - FIFO flushed; in-flight and pending requests discarded.
  - commit_prev=1, so a commit bit already held high through reset is not captured.
- Commit detect:
  - Capture when cpu_update_ctrl[9]=1 and commit_prev=0; commit_prev is a register of bit 9.
  - On capture, {ctrl[8:0], value} is sampled on that same edge.
  - The CPU must drop bit 9 before the next write.
- Capture filter, applied in order:
  - axis=3 → drop, set conflict_err.
  - bank equals that axis's current committed bank → drop, set conflict_err.
  - FIFO full and no pop on this edge → drop, set overflow_err.
  - Otherwise push.
  - Push and pop on the same edge are legal at full; level is unchanged.
- Issue:
  - Pop when FIFO non-empty, fir_busy=0 and sample_strobe=0.
  - The popped entry drives registered update_* with update_en=1 for exactly one cycle.
  - At most one write per cycle.
  - update_axis/bank/index/value hold their last values when update_en=0.
  - Latency: update_en is high in the cycle after the edge following capture, i.e. capture at edge k gives update_en high between edges k+1 and k+2, given an empty FIFO and an idle FIR.
- Bank swap, per axis independently:
  - Register holds req_bank; on any change of the *_bank_req input, latch it and set swap_pending[a].
  - If req equals the committed bank, clear swap_pending instead.
  - Commit on a sample_strobe edge only if no FIFO entry and no same-edge push targets (axis a, req bank). Commit copies req to *_bank and clears swap_pending[a].
  - Otherwise remain pending until a later strobe satisfies the condition.
- Sticky errors:
  - err_clear clears both flags.
  - A set event on the same edge as err_clear wins (flag stays 1).
- FSM per axis: IDLE → (req≠bank) PENDING → (strobe & clean) IDLE; reset → IDLE.
- fifo_level is registered and reflects post-edge occupancy.

Optional Feature:
- Macro COEFF_UPDATE_COUNT_EN.
- Defined: issued_count increments by 1 on every update_en pulse; 16-bit, wraps 0xFFFF→0x0000; cleared by reset only.
- Undefined: issued_count tied to 0 and no counter logic is generated.

Test Plan:
- Reset with ctrl[9] held 1, release, hold 3 cycles → no update_en. Then drop bit 9, raise it with axis=1, bank=2, index=5, value=0x1234 → update_en one cycle, 2 edges later, with matching fields.
- fir_busy=1, perform 9 commits (DEPTH=8) → fifo_level=8, overflow_err=1. Drop fir_busy → 8 consecutive update_en pulses in index order. err_clear → overflow_err=0.
- Commit with axis=3, then commit to x bank 0 while x_bank=0 → both dropped, conflict_err=1, fifo_level=0.
- Load 3 writes to x bank 1 under fir_busy, set x_bank_req=1, pulse sample_strobe → x_bank stays 0, swap_pending=3'b001. Release fir_busy, drain, next strobe → x_bank=1, swap_pending=0.
- Assert reset with 4 entries queued and y swap pending → next cycle fifo_level=0, swap_pending=0, y_bank=0, no update_en.
- With COEFF_UPDATE_COUNT_EN, preset count near wrap via 65537 issued writes → issued_count=1. Without macro → issued_count stays 0.

Source files
------------

// File: rtl/coeff_update_sequencer.sv
// Turns CPU PIO commit edges into FIFO-buffered, FIR-idle-gated coefficient write pulses,
// and commits per-axis bank swaps at sample boundaries. Optional macro: COEFF_UPDATE_COUNT_EN.
module coeff_update_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int COEFF_W    = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [9:0]         cpu_update_ctrl,
  input  logic [COEFF_W-1:0] cpu_update_value,
  input  logic [1:0]         x_bank_req,
  input  logic [1:0]         y_bank_req,
  input  logic [1:0]         z_bank_req,
  input  logic               err_clear,
  input  logic               sample_strobe,
  input  logic               fir_busy,
  output logic               update_en,
  output logic [1:0]         update_axis,
  output logic [1:0]         update_bank,
  output logic [4:0]         update_index,
  output logic [COEFF_W-1:0] update_value,
  output logic [1:0]         x_bank,
  output logic [1:0]         y_bank,
  output logic [1:0]         z_bank,
  output logic [LVL_W-1:0]   fifo_level,
  output logic [2:0]         swap_pending,
  output logic               overflow_err,
  output logic               conflict_err,
  output logic [15:0]        issued_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 9 + COEFF_W;

  typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

  logic [ENT_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic                  commit_prev;
  logic [2:0][1:0]       bank_q, req_q, req_in;
  swap_state_t           st [3];
  logic [FIFO_DEPTH-1:0] occ;
  logic [2:0]            hit;

  logic       capture, full, empty, pop, push;
  logic       axis_bad, bank_bad, ovf;
  logic [1:0] cap_axis, cap_bank;

  function automatic logic [1:0] axis_bank(input logic [1:0] ax, input logic [2:0][1:0] b);
    case (ax)
      2'd0:    axis_bank = b[0];
      2'd1:    axis_bank = b[1];
      default: axis_bank = b[2];
    endcase
  endfunction

  assign req_in   = {z_bank_req, y_bank_req, x_bank_req};
  assign cap_axis = cpu_update_ctrl[8:7];
  assign cap_bank = cpu_update_ctrl[6:5];
  assign capture  = cpu_update_ctrl[9] & ~commit_prev;
  assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty    = (fifo_level == '0);
  assign pop      = ~empty & ~fir_busy & ~sample_strobe;

  // Filter order: illegal axis, then active-bank write, then FIFO full.
  assign axis_bad = capture & (cap_axis == 2'd3);
  assign bank_bad = capture & ~axis_bad & (cap_bank == axis_bank(cap_axis, bank_q));
  assign ovf      = capture & ~axis_bad & ~bank_bad & full & ~pop;
  assign push     = capture & ~axis_bad & ~bank_bad & ~ovf;

  assign x_bank = bank_q[0];
  assign y_bank = bank_q[1];
  assign z_bank = bank_q[2];

  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off    = PTR_W'(i) - rd_ptr;
      occ[i] = (LVL_W'(off) < fifo_level);
    end
  end

  // A swap is blocked while any queued or same-edge write targets the requested bank.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      hit[a] = push && (cap_axis == 2'(a)) && (cap_bank == req_q[a]);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (occ[i] && (mem[i][ENT_W-1 -: 2] == 2'(a)) && (mem[i][ENT_W-3 -: 2] == req_q[a]))
          hit[a] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int a = 0; a < 3; a++) swap_pending[a] = (st[a] == S_PENDING);
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {cpu_update_ctrl[8:0], cpu_update_value};
  end

  // p0: capture/push, p1: registered write pulse
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      commit_prev  <= 1'b1;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_level   <= '0;
      update_en    <= 1'b0;
      update_axis  <= '0;
      update_bank  <= '0;
      update_index <= '0;
      update_value <= '0;
      overflow_err <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      commit_prev <= cpu_update_ctrl[9];
      update_en   <= pop;
      if (pop) begin
        {update_axis, update_bank, update_index, update_value} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (ovf)            overflow_err <= 1'b1;
      else if (err_clear) overflow_err <= 1'b0;
      if (axis_bad || bank_bad) conflict_err <= 1'b1;
      else if (err_clear)       conflict_err <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bank_q <= '0;
      req_q  <= '0;
      for (int a = 0; a < 3; a++) st[a] <= S_IDLE;
    end else begin
      for (int a = 0; a < 3; a++) begin
        if (req_in[a] != req_q[a]) begin
          req_q[a] <= req_in[a];
          st[a]    <= (req_in[a] == bank_q[a]) ? S_IDLE : S_PENDING;
        end else if (st[a] == S_PENDING && sample_strobe && !hit[a]) begin
          bank_q[a] <= req_q[a];
          st[a]     <= S_IDLE;
        end
      end
    end
  end

`ifdef COEFF_UPDATE_COUNT_EN
  logic [15:0] cnt;
  always_ff @(posedge sys_clk) begin
    if (reset)          cnt <= '0;
    else if (update_en) cnt <= cnt + 16'd1;
  end
  assign issued_count = cnt;
`else
  assign issued_count = '0;
`endif

endmodule

// File: tb/tb_coeff_update_sequencer.sv
// Self-checking bench for coeff_update_sequencer: vector table for the capture filter,
// hand sequences for latency, overflow, bank swap and reset, and a write scoreboard.
module tb_coeff_update_sequencer;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [9:0]  cpu_update_ctrl;
  logic [15:0] cpu_update_value;
  logic [1:0]  x_bank_req, y_bank_req, z_bank_req;
  logic        err_clear, sample_strobe, fir_busy;
  logic        update_en;
  logic [1:0]  update_axis, update_bank;
  logic [4:0]  update_index;
  logic [15:0] update_value;
  logic [1:0]  x_bank, y_bank, z_bank;
  logic [3:0]  fifo_level;
  logic [2:0]  swap_pending;
  logic        overflow_err, conflict_err;
  logic [15:0] issued_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;

  typedef struct packed {
    logic [1:0]  axis;
    logic [1:0]  bank;
    logic [4:0]  index;
    logic [15:0] value;
  } wr_t;

  typedef struct {
    logic [1:0]  axis;
    logic [1:0]  bank;
    logic [4:0]  index;
    logic [15:0] value;
    logic        exp_conflict;
    int          exp_level;
  } vec_t;

  wr_t sb [$];

  always #5 sys_clk = ~sys_clk;

  coeff_update_sequencer #(.FIFO_DEPTH(8), .COEFF_W(16)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .cpu_update_ctrl(cpu_update_ctrl), .cpu_update_value(cpu_update_value),
    .x_bank_req(x_bank_req), .y_bank_req(y_bank_req), .z_bank_req(z_bank_req),
    .err_clear(err_clear), .sample_strobe(sample_strobe), .fir_busy(fir_busy),
    .update_en(update_en), .update_axis(update_axis), .update_bank(update_bank),
    .update_index(update_index), .update_value(update_value),
    .x_bank(x_bank), .y_bank(y_bank), .z_bank(z_bank),
    .fifo_level(fifo_level), .swap_pending(swap_pending),
    .overflow_err(overflow_err), .conflict_err(conflict_err),
    .issued_count(issued_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write pulse must match the oldest expected write.
  always @(negedge sys_clk) begin
    if (update_en === 1'b1) begin
      n_issued++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %0h, expected no write",
                 {update_axis, update_bank, update_index, update_value});
      end else begin
        wr_t e;
        e = sb.pop_front();
        if ({update_axis, update_bank, update_index, update_value} !== e) begin
          n_fail++;
          $display("FAIL write_fields: got %0h, expected %0h",
                   {update_axis, update_bank, update_index, update_value}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_commit(input logic [1:0] ax, input logic [1:0] bk, input logic [4:0] idx,
                           input logic [15:0] val);
    cpu_update_ctrl  = {1'b1, ax, bk, idx};
    cpu_update_value = val;
    tick();
    cpu_update_ctrl[9] = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (fifo_level != 0 && cyc < 40) begin
      tick();
      cyc++;
    end
    tick();
    check(name, fifo_level, 0);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2'd3, 2'd1, 5'd1, 16'h0AAA, 1'b1, 0};
    vecs[1] = '{2'd0, 2'd0, 5'd2, 16'h0BBB, 1'b1, 0};
    vecs[2] = '{2'd2, 2'd1, 5'd3, 16'h0CCC, 1'b0, 1};
    vecs[3] = '{2'd1, 2'd0, 5'd4, 16'h0DDD, 1'b1, 1};
    vecs[4] = '{2'd1, 2'd3, 5'd6, 16'h0EEE, 1'b0, 2};
    vecs[5] = '{2'd3, 2'd0, 5'd7, 16'h0FFF, 1'b1, 2};

    reset = 1'b1;
    cpu_update_ctrl  = {1'b1, 2'd1, 2'd2, 5'd5};
    cpu_update_value = 16'h1234;
    {x_bank_req, y_bank_req, z_bank_req} = '0;
    {err_clear, sample_strobe, fir_busy} = '0;
    repeat (3) tick();
    check("rst_update_en", update_en, 0);
    check("rst_fields", {update_axis, update_bank, update_index, update_value}, 0);
    check("rst_banks", {x_bank, y_bank, z_bank}, 0);
    check("rst_level_swap", {fifo_level, swap_pending}, 0);
    check("rst_errs", {overflow_err, conflict_err}, 0);
    check("rst_count", issued_count, 0);

    // Commit bit held through reset must not be captured.
    reset = 1'b0;
    repeat (3) tick();
    check("held_commit_level", fifo_level, 0);
    cpu_update_ctrl[9] = 1'b0;
    tick();
    cpu_update_ctrl = {1'b1, 2'd1, 2'd2, 5'd5};
    sb.push_back('{2'd1, 2'd2, 5'd5, 16'h1234});
    tick();
    check("lat_edge_k_en", update_en, 0);
    check("lat_edge_k_level", fifo_level, 1);
    cpu_update_ctrl[9] = 1'b0;
    tick();
    check("lat_edge_k1_en", update_en, 1);
    check("lat_edge_k1_fields", {update_axis, update_bank, update_index, update_value},
          {2'd1, 2'd2, 5'd5, 16'h1234});
    tick();
    check("lat_one_cycle", update_en, 0);
    check("lat_hold_index", update_index, 5);

    // Overflow: 9 writes into an 8-deep FIFO while the FIR is busy.
    fir_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back('{2'd0, 2'd1, 5'(i), 16'h0100 + 16'(i)});
      do_commit(2'd0, 2'd1, 5'(i), 16'h0100 + 16'(i));
    end
    check("ovf_level", fifo_level, 8);
    check("ovf_err", overflow_err, 1);
    fir_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("burst_en", update_en, 1);
      check("burst_index", update_index, i);
    end
    tick();
    check("burst_end", {update_en, fifo_level}, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("ovf_clear", overflow_err, 0);

    // Capture filter vectors, FIR busy so accepted writes stay queued.
    fir_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      if (!vecs[i].exp_conflict)
        sb.push_back('{vecs[i].axis, vecs[i].bank, vecs[i].index, vecs[i].value});
      do_commit(vecs[i].axis, vecs[i].bank, vecs[i].index, vecs[i].value);
      check("vec_conflict", conflict_err, vecs[i].exp_conflict);
      check("vec_level", fifo_level, vecs[i].exp_level);
    end
    fir_busy = 1'b0;
    drain("vec_drain");

    // Bank swap deferred while writes to the requested bank are queued.
    fir_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{2'd0, 2'd1, 5'(20 + i), 16'h0A00 + 16'(i)});
      do_commit(2'd0, 2'd1, 5'(20 + i), 16'h0A00 + 16'(i));
    end
    x_bank_req = 2'd1;
    tick();
    check("swap_req_pending", swap_pending, 3'b001);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("swap_blocked_bank", x_bank, 0);
    check("swap_blocked_pending", swap_pending, 3'b001);
    fir_busy = 1'b0;
    drain("swap_drain");
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("swap_commit_bank", x_bank, 1);
    check("swap_commit_pending", swap_pending, 0);

    // Reset discards queued writes and pending swaps.
    fir_busy = 1'b1;
    for (int i = 0; i < 4; i++) do_commit(2'd0, 2'd2, 5'(i), 16'h0B00 + 16'(i));
    y_bank_req = 2'd1;
    tick();
    check("pre_rst_level", fifo_level, 4);
    check("pre_rst_pending", swap_pending, 3'b010);
    reset = 1'b1;
    x_bank_req = 2'd0;
    y_bank_req = 2'd0;
    fir_busy = 1'b0;
    tick();
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_pending", swap_pending, 0);
    check("mid_rst_banks", {x_bank, y_bank}, 0);
    check("mid_rst_en", update_en, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("post_rst_level", fifo_level, 0);
    n_issued = 0;

    // Issue counter after two more writes.
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{2'd2, 2'd3, 5'(i), 16'hC000 + 16'(i)});
      do_commit(2'd2, 2'd3, 5'(i), 16'hC000 + 16'(i));
    end
    drain("cnt_drain");
    check("issued_seen", n_issued, 2);
`ifdef COEFF_UPDATE_COUNT_EN
    check("issued_count", issued_count, 2);
`else
    check("issued_count", issued_count, 0);
`endif
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
